// File: rtl/bcd_to_binary_transcoder.sv
// bcd_to_binary_transcoder
// Converts a packed-BCD word into its binary value with the reverse
// double-dabble algorithm: each clock shifts one bit from the BCD register
// into the binary register. Each nibble that reaches 8 or more after the
// shift is then reduced by 3. A one-hot sequencer marks the last cycle of each pass.
// At that edge the result is published and a new input word is sampled.

`ifdef REUSABLES_CHECKERS_ENABLED
// Sequencer integrity checker: the pass sequencer must stay one-hot.
module bcd_to_binary_transcoder_onehot_chk #(
  parameter int W = 4
) (
  input logic         clk,
  input logic         reset_n,
  input logic [W-1:0] state
);
  a_state_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot(state));
endmodule
`endif

module bcd_to_binary_transcoder #(
  parameter int DIGITS    = 3,
  parameter int OUT_WIDTH = $clog2(10 ** DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [4*DIGITS-1:0]   in,
  output logic [OUT_WIDTH-1:0]  out,
  output logic                  out_valid,
  output logic                  out_err
);

  // Subtract 3 from every nibble that is 8 or more; nibbles never borrow.
  function automatic logic [4*DIGITS-1:0] adjust_nibbles(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    logic [3:0]          nib;
    r = {(4*DIGITS){1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      nib = v[4*i +: 4];
      if (nib >= 4'd8) begin
        r[4*i +: 4] = nib - 4'd3;
      end else begin
        r[4*i +: 4] = nib;
      end
    end
    return r;
  endfunction

  // Flag a word holding any nibble outside the decimal range 0..9.
  function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  logic [OUT_WIDTH-1:0] state;
  logic [OUT_WIDTH-1:0] next_state;
  logic                 ready;
  logic [4*DIGITS-1:0]  bcd_reg;
  logic [OUT_WIDTH-1:0] bin_reg;
  logic                 err_reg;
  logic [OUT_WIDTH-1:0] next_bin;
  logic [4*DIGITS-1:0]  shifted;
  logic [4*DIGITS-1:0]  adjusted;
  logic                 in_err;

  assign ready = state[OUT_WIDTH-1];

  // Next-state and datapath step: shift one bit across, correct the BCD nibbles.
  always_comb begin
    next_state = {{(OUT_WIDTH-1){1'b0}}, 1'b1};
    next_bin   = {bcd_reg[0], bin_reg[OUT_WIDTH-1:1]};
    shifted    = bcd_reg >> 1;
    adjusted   = adjust_nibbles(shifted);
    in_err     = has_bad_digit(in);
    if (ready) begin
      next_state = {{(OUT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      next_state = state << 1;
    end
  end

  // One-hot pass sequencer register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= {{(OUT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      state <= next_state;
    end
  end

  // Conversion datapath: load a fresh word at the ready edge, else step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcd_reg <= {(4*DIGITS){1'b0}};
      bin_reg <= {OUT_WIDTH{1'b0}};
      err_reg <= 1'b0;
    end else if (ready) begin
      bcd_reg <= in;
      bin_reg <= {OUT_WIDTH{1'b0}};
      err_reg <= in_err;
    end else begin
      bcd_reg <= adjusted;
      bin_reg <= next_bin;
      err_reg <= err_reg;
    end
  end

  // Result publication: the ready edge completes the last shift and strobes valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out       <= {OUT_WIDTH{1'b0}};
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else if (ready) begin
      out       <= err_reg ? {OUT_WIDTH{1'b0}} : next_bin;
      out_err   <= err_reg;
      out_valid <= 1'b1;
    end else begin
      out       <= out;
      out_err   <= out_err;
      out_valid <= 1'b0;
    end
  end

`ifdef REUSABLES_CHECKERS_ENABLED
  bcd_to_binary_transcoder_onehot_chk #(.W(OUT_WIDTH)) u_onehot_chk (
    .clk     (clk),
    .reset_n (reset_n),
    .state   (state)
  );
`endif

endmodule

// File: tb/tb_bcd_to_binary_transcoder.sv
// Bench for bcd_to_binary_transcoder: a DIGITS=3 and a DIGITS=1 instance run
// side by side. A cycle-counting decimal model predicts every output on
// every cycle; directed vectors add hand-computed literal expectations.
module tb_bcd_to_binary_transcoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] in_a = 12'h000;
  logic [3:0]  in_b = 4'h0;
  logic [9:0]  out_a;
  logic        out_valid_a;
  logic        out_err_a;
  logic [3:0]  out_b;
  logic        out_valid_b;
  logic        out_err_b;

  int checks = 0;
  int errors = 0;

  bcd_to_binary_transcoder #(.DIGITS(3)) dut_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .in        (in_a),
    .out       (out_a),
    .out_valid (out_valid_a),
    .out_err   (out_err_a)
  );

  bcd_to_binary_transcoder #(.DIGITS(1)) dut_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .in        (in_b),
    .out       (out_b),
    .out_valid (out_valid_b),
    .out_err   (out_err_b)
  );

  always #5 clk = ~clk;

  // Decimal meaning of a BCD word: bit 32 = bad digit present, [31:0] = value.
  function automatic logic [32:0] dec(input logic [35:0] v, input int nd);
    longint     val;
    logic       bad;
    logic [3:0] d;
    val = 0;
    bad = 1'b0;
    for (int i = nd - 1; i >= 0; i--) begin
      d = v[4*i +: 4];
      if (d > 4'd9) bad = 1'b1;
      val = val * 10 + longint'(d);
    end
    return {bad, val[31:0]};
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a pass is P cycles; at each P-th edge publish the previously sampled word.
  int          ca = 0, cb = 0;
  logic [32:0] pa = 33'd0, pb = 33'd0;
  longint      ea_out = 0, eb_out = 0;
  logic        ea_err = 1'b0, ea_v = 1'b0, eb_err = 1'b0, eb_v = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ca <= 0; pa <= 33'd0; ea_out <= 0; ea_err <= 1'b0; ea_v <= 1'b0;
      cb <= 0; pb <= 33'd0; eb_out <= 0; eb_err <= 1'b0; eb_v <= 1'b0;
    end else begin
      ca <= (ca == 9) ? 0 : ca + 1;
      if (ca == 9) begin
        ea_v <= 1'b1; ea_err <= pa[32]; ea_out <= pa[32] ? 0 : longint'(pa[31:0]);
        pa <= dec({24'd0, in_a}, 3);
      end else begin
        ea_v <= 1'b0;
      end
      cb <= (cb == 3) ? 0 : cb + 1;
      if (cb == 3) begin
        eb_v <= 1'b1; eb_err <= pb[32]; eb_out <= pb[32] ? 0 : longint'(pb[31:0]);
        pb <= dec({32'd0, in_b}, 1);
      end else begin
        eb_v <= 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model while out of reset.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("model_a_out",   longint'(out_a),       ea_out);
      chk("model_a_valid", longint'(out_valid_a), longint'(ea_v));
      chk("model_a_err",   longint'(out_err_a),   longint'(ea_err));
      chk("model_b_out",   longint'(out_b),       eb_out);
      chk("model_b_valid", longint'(out_valid_b), longint'(eb_v));
      chk("model_b_err",   longint'(out_err_b),   longint'(eb_err));
    end
  end

  // Wait (bounded) for a strobe on instance a (sel=0) or b (sel=1); returns negedges waited.
  task automatic wait_strobe(input bit sel, output int cycles);
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cycles++;
      if (sel ? out_valid_b : out_valid_a) return;
    end
    chk(sel ? "timeout_b" : "timeout_a", 0, 1);
  endtask

  int n;

  initial begin
    // Pin the model with hand-computed values.
    chk("dec_999", longint'(dec(36'h999, 3)), 999);
    chk("dec_512", longint'(dec(36'h512, 3)), 512);
    chk("dec_0a5_err", longint'(dec(36'h0A5, 3) >> 32), 1);
    chk("dec_7", longint'(dec(36'h7, 1)), 7);

    repeat (3) @(negedge clk);
    chk("reset_out", longint'(out_a), 0);
    chk("reset_valid", longint'(out_valid_a), 0);
    chk("reset_err", longint'(out_err_a), 0);
    reset_n = 1'b1;

    wait_strobe(1'b0, n);
    chk("first_strobe_cycle", n, 10);
    chk("first_out_zero", longint'(out_a), 0);
    wait_strobe(1'b0, n);
    chk("strobe_period", n, 10);

    in_a = 12'h999;
    wait_strobe(1'b0, n); wait_strobe(1'b0, n);
    chk("out_999", longint'(out_a), 10'h3E7);
    chk("err_999", longint'(out_err_a), 0);

    in_a = 12'h512;
    wait_strobe(1'b0, n); wait_strobe(1'b0, n);
    chk("out_512", longint'(out_a), 512);

    in_a = 12'h0A5;
    wait_strobe(1'b0, n); wait_strobe(1'b0, n);
    chk("out_0a5", longint'(out_a), 0);
    chk("err_0a5", longint'(out_err_a), 1);

    in_a = 12'h042;
    wait_strobe(1'b0, n); wait_strobe(1'b0, n);
    chk("out_42", longint'(out_a), 42);
    chk("err_42", longint'(out_err_a), 0);

    in_a = 12'h123;
    wait_strobe(1'b0, n);
    repeat (3) @(negedge clk);
    in_a = 12'h876;
    wait_strobe(1'b0, n);
    chk("out_123_held", longint'(out_a), 123);
    wait_strobe(1'b0, n);
    chk("out_876", longint'(out_a), 876);

    in_a = 12'h999;
    wait_strobe(1'b0, n); wait_strobe(1'b0, n);
    chk("out_999_again", longint'(out_a), 999);
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_out", longint'(out_a), 0);
    chk("async_valid", longint'(out_valid_a), 0);
    chk("async_err", longint'(out_err_a), 0);
    chk("async_out_b", longint'(out_b), 0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_strobe(1'b0, n);
    chk("restart_strobe_cycle", n, 10);
    chk("restart_out_zero", longint'(out_a), 0);

    // DIGITS=1 sweep over every nibble value.
    wait_strobe(1'b1, n);
    for (int v = 0; v < 16; v++) begin
      in_b = 4'(v);
      wait_strobe(1'b1, n); wait_strobe(1'b1, n);
      chk("sweep_b_out", longint'(out_b), (v <= 9) ? v : 0);
      chk("sweep_b_err", longint'(out_err_b), (v <= 9) ? 0 : 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
